// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch-stage PC generator with boot cycle, redirect and stall capture
module fetch_pc_gen #(
    parameter int              XLEN         = 32,
    parameter int              FETCH_WIDTH  = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   pc_we_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic [XLEN-1:0]        pc_o,
    output logic [FETCH_WIDTH-1:0] slot_valid_o,
    output logic                   fetch_valid_o,
    output logic                   stall_o,
    output logic                   flush_o
);

    localparam int GROUP_BYTES = 4 * FETCH_WIDTH;
    localparam int OFF_W       = $clog2(GROUP_BYTES);
    localparam int SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [FETCH_WIDTH-1:0] mask_q, mask_d;
    logic                   flush_q, flush_d;
    // Pending target kept as a word address; byte offset bits are never used.
    logic [XLEN-3:0]        pend_q, pend_d;

    logic [XLEN-3:0]        tgt_word;
    logic [XLEN-1:0]        tgt_pc;
    logic [SLOT_W-1:0]      tgt_slot;
    logic [FETCH_WIDTH-1:0] tgt_mask;
    logic                   unused_pc_lo;

    assign unused_pc_lo = ^redirect_pc_i[1:0];

    // A same-cycle redirect beats whatever was captured while stalled.
    assign tgt_word = ((state_q == ST_HOLD) && !redirect_i) ? pend_q : redirect_pc_i[XLEN-1:2];
    assign tgt_pc   = {tgt_word[XLEN-3:OFF_W-2], {OFF_W{1'b0}}};

    generate
        if (FETCH_WIDTH > 1) begin : g_slot
            assign tgt_slot = tgt_word[OFF_W-3:0];
        end else begin : g_noslot
            assign tgt_slot = '0;
        end
    endgenerate

    // Slots before the redirect target inside its group are invalid.
    always_comb begin
        tgt_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            tgt_mask[i] = (SLOT_W'(i) >= tgt_slot);
        end
    end

    // Next-state and next-output selection for BOOT/RUN/HOLD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        flush_d = 1'b0;
        pend_d  = pend_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i && pc_we_i) begin
                    pc_d    = tgt_pc;
                    mask_d  = tgt_mask;
                    flush_d = 1'b1;
                end else if (redirect_i) begin
                    pend_d  = redirect_pc_i[XLEN-1:2];
                    state_d = ST_HOLD;
                end else if (pc_we_i) begin
                    pc_d   = pc_q + XLEN'(GROUP_BYTES);
                    mask_d = '1;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pend_d = redirect_pc_i[XLEN-1:2];
                end
                if (pc_we_i) begin
                    pc_d    = tgt_pc;
                    mask_d  = tgt_mask;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and output registers; reset lands in BOOT at the reset vector.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            mask_q  <= '1;
            flush_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            flush_q <= flush_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_o          = pc_q;
    assign slot_valid_o  = mask_q;
    assign fetch_valid_o = (state_q != ST_BOOT);
    assign stall_o       = (state_q == ST_HOLD);
    assign flush_o       = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen against a queue-based reference
module tb_fetch_pc_gen;

    localparam int          FW = 2;
    localparam logic [31:0] RV = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_we = 1'b0;
    logic          redir = 1'b0;
    logic [31:0]   rpc = '0;
    logic [31:0]   pc;
    logic [FW-1:0] slot;
    logic          fvalid;
    logic          stall;
    logic          flush;

    fetch_pc_gen #(.XLEN(32), .FETCH_WIDTH(FW), .RESET_VECTOR(RV)) dut (
        .clock_i       (clk),
        .reset_n_i     (rst_n),
        .pc_we_i       (pc_we),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .pc_o          (pc),
        .slot_valid_o  (slot),
        .fetch_valid_o (fvalid),
        .stall_o       (stall),
        .flush_o       (flush)
    );

    always #5 clk = ~clk;

    // Expected record: {pc, mask, fetch_valid, stall, flush}
    logic [36:0]   exp_q[$];
    logic [31:0]   pend[$];
    logic [31:0]   m_pc;
    logic [FW-1:0] m_mask;
    bit            m_valid;
    bit            m_flush;
    bit            m_booted;
    int            vectors = 0;
    int            errors = 0;

    task automatic model_update(input bit in_reset);
        logic [31:0] t;
        if (in_reset) begin
            m_pc     = RV;
            m_mask   = '1;
            m_valid  = 1'b0;
            m_flush  = 1'b0;
            m_booted = 1'b0;
            pend.delete();
        end else if (!m_booted) begin
            m_booted = 1'b1;
            m_valid  = 1'b1;
            m_flush  = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (redir) pend.push_back(rpc);
            if (pc_we) begin
                if (pend.size() > 0) begin
                    t = pend[pend.size()-1];
                    pend.delete();
                    m_pc = t & ~32'(4 * FW - 1);
                    for (int i = 0; i < FW; i++) m_mask[i] = (i >= ((t >> 2) % FW));
                    m_flush = 1'b1;
                end else begin
                    m_pc   = m_pc + 32'(4 * FW);
                    m_mask = '1;
                end
            end
        end
        exp_q.push_back({m_pc, m_mask, m_valid, (pend.size() != 0), m_flush});
    endtask

    task automatic monitor_check();
        logic [36:0] e;
        logic [36:0] a;
        vectors++;
        a = {pc, slot, fvalid, stall, flush};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow t=%0t actual=%h", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual pc=%h slot=%b v=%b stall=%b flush=%b required pc=%h slot=%b v=%b stall=%b flush=%b",
                         $time, a[36:5], a[4:3], a[2], a[1], a[0], e[36:5], e[4:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Reference model: advances on every clock edge or reset assertion.
    always @(posedge clk or negedge rst_n) model_update(!rst_n);

    // Monitor: samples the DUT shortly after every event the model reacts to.
    always @(posedge clk or negedge rst_n) begin
        #1;
        monitor_check();
    end

    task automatic step(input logic w, input logic r, input logic [31:0] p);
        pc_we = w;
        redir = r;
        rpc   = p;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h104);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h200);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h300);
        step(1'b0, 1'b1, 32'h404);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h500);
        step(1'b1, 1'b1, 32'h50C);
        step(1'b1, 1'b1, 32'h5F4);
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h600);
        step(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0, 32'h0);
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
        end
        step(1'b0, 1'b0, 32'h0);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
